// File: rtl/alu_datapath_pkg.sv
// Shared definitions for the ALU datapath slice.
// Holds the default datapath width and the 3-bit ALU operation codes.
// Operation codes with bit 2 set invert operand B before it enters the
// adder and logic units. The adder carry-in is also tied to bit 2.
package alu_datapath_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_AND     = 3'b000,
        ALU_OR      = 3'b001,
        ALU_ADD     = 3'b010,
        ALU_ADD_RSV = 3'b011,  // reserved encoding, behaves as ADD
        ALU_ANDN    = 3'b100,
        ALU_ORN     = 3'b101,
        ALU_SUB     = 3'b110,
        ALU_SLT     = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_datapath_if.sv
// Bundle of the ALU datapath operand, control and result signals.
//   srca, regb, imm  : operand A, register operand B, immediate operand B
//   alusrc           : 0 selects regb, 1 selects imm as operand B
//   aluctrl          : operation code (alu_op_e encoding)
//   result/cout/zero : combinational ALU outputs
//   result_q/zero_q  : result and zero registered on clk
// Modports:
//   master : the side that supplies operands and observes the results.
//   slave  : the datapath itself.
// There is no handshake. Inputs are sampled continuously, so result,
// cout and zero follow them with no delay. The registered outputs
// capture result and zero on every rising clock edge.
interface alu_datapath_if
    import alu_datapath_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] regb;
    logic [WIDTH-1:0] imm;
    logic             alusrc;
    logic [2:0]       aluctrl;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    modport master (
        output srca, regb, imm, alusrc, aluctrl,
        input  result, cout, zero, result_q, zero_q
    );

    modport slave (
        input  srca, regb, imm, alusrc, aluctrl,
        output result, cout, zero, result_q, zero_q
    );
endinterface

// File: rtl/alu_datapath_alu.sv
// Combinational ALU.
//   a, b   : operands (WIDTH bits)
//   ctrl   : operation code (alu_op_e encoding)
//   result : operation result
//   cout   : adder carry out of bit WIDTH-1, driven for every opcode
//   zero   : 1 when result is all zeros
module alu
    import alu_datapath_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ctrl,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic             w_slt;

    // When bit 2 is set, operand B is inverted and a carry-in of one is
    // added. This gives the two's-complement subtract a + ~b + 1.
    assign w_b_eff       = ctrl[2] ? ~b : b;
    assign {cout, w_sum} = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, ctrl[2]};

    // Signed overflow occurs when both adder inputs have the same sign and
    // the sum has the other sign. XOR-ing overflow with the sum sign gives
    // the correct signed less-than even when a - b wraps.
    assign w_ovf = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    assign w_slt = w_sum[WIDTH-1] ^ w_ovf;

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_AND,
            ALU_ANDN:    result = a & w_b_eff;
            ALU_OR,
            ALU_ORN:     result = a | w_b_eff;
            ALU_ADD,
            ALU_ADD_RSV,
            ALU_SUB:     result = w_sum;
            ALU_SLT:     result = {{(WIDTH-1){1'b0}}, w_slt};
            default:     result = '0;
        endcase
    end

    assign zero = ~|result;
endmodule

// File: rtl/alu_datapath_flopr.sv
// D flip-flop register with an asynchronous, active-high reset.
//   clk   : rising-edge clock
//   reset : asynchronous reset; q holds RESET_VALUE while reset is high
//   d     : next value
//   q     : registered value
module flopr #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= RESET_VALUE;
        else       q <= d;
    end
endmodule

// File: rtl/alu_datapath_mux2.sv
// Generic 2:1 multiplexer.
//   d0, d1 : data inputs (WIDTH bits)
//   s      : select, 0 picks d0 and 1 picks d1
//   y      : selected data
module mux2 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);
    assign y = s ? d1 : d0;
endmodule

// File: rtl/alu_datapath.sv
// ALU datapath: operand-B mux, combinational ALU and output register.
//   clk   : rising-edge clock for result_q/zero_q
//   reset : asynchronous, active-high reset of the output register only
//   bus   : alu_datapath_if.slave carrying operands, control and results
// result, cout and zero are combinational. result_q and zero_q are those
// values delayed by one clock edge.
module alu_datapath
    import alu_datapath_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         reset,
    alu_datapath_if.slave bus
);
    logic [WIDTH-1:0] w_srcb;
    logic [WIDTH-1:0] w_result;
    logic             w_cout;
    logic             w_zero;
    logic [WIDTH:0]   r_q;

    mux2 #(.WIDTH(WIDTH)) u_srcb_mux (
        .d0 (bus.regb),
        .d1 (bus.imm),
        .s  (bus.alusrc),
        .y  (w_srcb)
    );

    alu #(.WIDTH(WIDTH)) u_alu (
        .a      (bus.srca),
        .b      (w_srcb),
        .ctrl   (bus.aluctrl),
        .result (w_result),
        .cout   (w_cout),
        .zero   (w_zero)
    );

    // One register holds both outputs. The zero flag is in the MSB and
    // resets to 0, whatever RESET_VALUE is.
    flopr #(
        .WIDTH       (WIDTH + 1),
        .RESET_VALUE ({1'b0, RESET_VALUE})
    ) u_out_reg (
        .clk   (clk),
        .reset (reset),
        .d     ({w_zero, w_result}),
        .q     (r_q)
    );

    assign bus.result   = w_result;
    assign bus.cout     = w_cout;
    assign bus.zero     = w_zero;
    assign bus.result_q = r_q[WIDTH-1:0];
    assign bus.zero_q   = r_q[WIDTH];
endmodule

// File: tb/tb_alu_datapath.sv
// Directed testbench for alu_datapath (WIDTH=32, RESET_VALUE=0).
module tb_alu_datapath;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    alu_datapath_if #(.WIDTH(W)) bus ();

    alu_datapath #(.WIDTH(W), .RESET_VALUE(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] rb,
                         input logic [W-1:0] im, input logic sel,
                         input logic [2:0] op);
        bus.srca    = a;
        bus.regb    = rb;
        bus.imm     = im;
        bus.alusrc  = sel;
        bus.aluctrl = op;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(32'd5, 32'd7, 32'd0, 1'b0, 3'b010);
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (bus.result_q !== 32'h0 || bus.zero_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: result_q=%h zero_q=%b required 0/0", bus.result_q, bus.zero_q);
        end
        n_tests++;
        if (bus.result !== 32'd12) begin
            n_fail++;
            $display("FAIL reset_comb: result=%h required 0000000c", bus.result);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus.result_q !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_release_nocap: result_q=%h required 0", bus.result_q);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.result_q !== 32'd12 || bus.zero_q !== 1'b0) begin
            n_fail++;
            $display("FAIL first_edge_load: result_q=%h zero_q=%b required 0000000c/0", bus.result_q, bus.zero_q);
        end
    endtask

    task automatic test_add();
        @(negedge clk);
        drive(32'd5, 32'd7, 32'hDEADBEEF, 1'b0, 3'b010);
        #1;
        n_tests++;
        if (bus.result !== 32'd12 || bus.zero !== 1'b0 || bus.cout !== 1'b0) begin
            n_fail++;
            $display("FAIL add: result=%h zero=%b cout=%b required 0000000c/0/0", bus.result, bus.zero, bus.cout);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.result_q !== 32'd12) begin
            n_fail++;
            $display("FAIL add_q: result_q=%h required 0000000c", bus.result_q);
        end
    endtask

    task automatic test_sub_equal();
        @(negedge clk);
        drive(32'h00001234, 32'h00001234, 32'h0, 1'b0, 3'b110);
        #1;
        n_tests++;
        if (bus.result !== 32'h0 || bus.zero !== 1'b1 || bus.cout !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_eq: result=%h zero=%b cout=%b required 0/1/1", bus.result, bus.zero, bus.cout);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.zero_q !== 1'b1 || bus.result_q !== 32'h0) begin
            n_fail++;
            $display("FAIL sub_eq_q: zero_q=%b result_q=%h required 1/0", bus.zero_q, bus.result_q);
        end
        // 3 - 5 wraps to -2 with a borrow (cout=0)
        @(negedge clk);
        drive(32'd3, 32'd5, 32'h0, 1'b0, 3'b110);
        #1;
        n_tests++;
        if (bus.result !== 32'hFFFFFFFE || bus.cout !== 1'b0 || bus.zero !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_wrap: result=%h cout=%b zero=%b required fffffffe/0/0", bus.result, bus.cout, bus.zero);
        end
    endtask

    task automatic test_imm();
        @(negedge clk);
        drive(32'h00400004, 32'h11111111, 32'hFFFFFFFC, 1'b1, 3'b010);
        #1;
        n_tests++;
        if (bus.result !== 32'h00400000 || bus.cout !== 1'b1) begin
            n_fail++;
            $display("FAIL imm_sel: result=%h cout=%b required 00400000/1", bus.result, bus.cout);
        end
        // reserved opcode 011 behaves as ADD
        bus.aluctrl = 3'b011;
        #1;
        n_tests++;
        if (bus.result !== 32'h00400000 || bus.cout !== 1'b1) begin
            n_fail++;
            $display("FAIL add_rsv: result=%h cout=%b required 00400000/1", bus.result, bus.cout);
        end
    endtask

    task automatic test_logic();
        logic [2:0]  ops [4];
        logic [31:0] exp [4];
        logic        exp_c [4];
        ops = '{3'b000, 3'b001, 3'b100, 3'b101};
        exp = '{32'hF000F000, 32'hFFF0FFF0, 32'h00F000F0, 32'hF0FFF0FF};
        // adder carry for F0F0F0F0+FF00FF00 and F0F0F0F0+00FF00FF+1
        exp_c = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 1'b0, ops[i]);
            #1;
            n_tests++;
            if (bus.result !== exp[i] || bus.cout !== exp_c[i] || bus.zero !== 1'b0) begin
                n_fail++;
                $display("FAIL logic_op%b: result=%h cout=%b zero=%b required %h/%b/0",
                         ops[i], bus.result, bus.cout, bus.zero, exp[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_slt();
        logic [31:0] av [4];
        logic [31:0] bv [4];
        logic [31:0] ex [4];
        logic        ez [4];
        av = '{32'hFFFFFFFF, 32'h00000001, 32'h80000000, 32'h00000005};
        bv = '{32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'h00000005};
        ex = '{32'd1, 32'd0, 32'd1, 32'd0};
        ez = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(av[i], bv[i], 32'h0, 1'b0, 3'b111);
            #1;
            n_tests++;
            if (bus.result !== ex[i] || bus.zero !== ez[i]) begin
                n_fail++;
                $display("FAIL slt%0d: a=%h b=%h result=%h zero=%b required %h/%b",
                         i, av[i], bv[i], bus.result, bus.zero, ex[i], ez[i]);
            end
        end
        // 5 - 5 carries out
        n_tests++;
        if (bus.cout !== 1'b1) begin
            n_fail++;
            $display("FAIL slt_cout: cout=%b required 1", bus.cout);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(32'd5, 32'd7, 32'h0, 1'b0, 3'b010);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (bus.result_q !== 32'h0 || bus.zero_q !== 1'b0 || bus.result !== 32'd12) begin
            n_fail++;
            $display("FAIL reset_mid: result_q=%h zero_q=%b result=%h required 0/0/0000000c",
                     bus.result_q, bus.zero_q, bus.result);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.result_q !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_override: result_q=%h required 0", bus.result_q);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.result_q !== 32'd12) begin
            n_fail++;
            $display("FAIL reset_recover: result_q=%h required 0000000c", bus.result_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_q [$];
        logic [W-1:0] av [5];
        logic [W-1:0] bv [5];
        logic [2:0]   ov [5];
        logic [W-1:0] ev [5];
        logic [W-1:0] e;
        av = '{32'd100, 32'hFFFFFFFF, 32'd9, 32'h0F0F0F0F, 32'd0};
        bv = '{32'd23,  32'd1,        32'd4, 32'h00FF00FF, 32'd0};
        ov = '{3'b010,  3'b010,       3'b110, 3'b000,      3'b001};
        ev = '{32'd123, 32'd0,        32'd5, 32'h000F000F, 32'd0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(av[i], bv[i], 32'h0, 1'b0, ov[i]);
            exp_q.push_back(ev[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_tests++;
            if (bus.result_q !== e || bus.zero_q !== (e == '0)) begin
                n_fail++;
                $display("FAIL b2b%0d: result_q=%h zero_q=%b required %h/%b",
                         i, bus.result_q, bus.zero_q, e, (e == '0));
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_add();
        test_sub_equal();
        test_imm();
        test_logic();
        test_slt();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_datapath.md
ALU_DATAPATH -- requirements
Module: alu_datapath

Interface
REQ-001 Parameter WIDTH, default 32: datapath width of operands, result and register.
REQ-002 Parameter RESET_VALUE, default 0: value loaded into registered outputs on reset.
REQ-003 clk  input  1  rising-edge clock for the output register.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 srca  input  WIDTH  ALU operand A.
REQ-006 regb  input  WIDTH  register-sourced candidate for operand B.
REQ-007 imm  input  WIDTH  sign-extended immediate, the other candidate for operand B.
REQ-008 alusrc  input  1  operand-B select: 0 selects regb, 1 selects imm.
REQ-009 aluctrl  input  3  operation code.
REQ-010 result  output  WIDTH  combinational ALU result.
REQ-011 cout  output  1  combinational adder carry-out.
REQ-012 zero  output  1  combinational flag, 1 when result == 0.
REQ-013 result_q  output  WIDTH  result registered on clk.
REQ-014 zero_q  output  1  zero registered on clk.

Function
REQ-015 Operand B SHALL be produced by a 2:1 mux: srcb = alusrc ? imm : regb.
REQ-016 aluctrl decode SHALL be: 000 A&B; 001 A|B; 010 A+B; 011 A+B (reserved, same as ADD); 100 A&~B; 101 A|~B; 110 A-B; 111 SLT.
REQ-017 The adder SHALL compute A + (aluctrl[2] ? ~B : B) + aluctrl[2], so subtract is two's-complement A+~B+1.
REQ-018 cout SHALL be the carry out of bit WIDTH-1 of that adder for every opcode, including logic ops, whose result does not use it.
REQ-019 SLT SHALL return 1 (zero-extended to WIDTH) when A < B as signed values; otherwise 0.
REQ-020 SLT SHALL use (sum MSB XOR signed overflow), so it is correct at extremes: A=0x80000000, B=1 gives 1.
REQ-021 Arithmetic SHALL wrap modulo 2^WIDTH; no overflow flag or trap is produced.
REQ-022 zero SHALL be the NOR of all result bits, valid for every opcode.
REQ-023 result, cout and zero SHALL be purely combinational: zero-cycle latency from any input.
REQ-024 result_q/zero_q SHALL capture result/zero on each rising clk edge while reset is low: one-cycle latency, no enable.

Reset
REQ-025 While reset is high, result_q SHALL be RESET_VALUE and zero_q SHALL be 0, immediately and independent of clk.
REQ-026 Reset SHALL NOT affect combinational outputs result, cout and zero.
REQ-027 After reset deasserts, the first rising edge SHALL load the current result.
REQ-028 Reset asserted mid-operation SHALL override any capture on the same edge.

Structure
REQ-029 A shared package SHALL hold the 3-bit ALU opcode constants: AND, OR, ADD, ANDN, ORN, SUB, SLT.
REQ-030 The package SHALL hold the default WIDTH.
REQ-031 The block SHALL be built from three sub-modules:
- mux2 (parameterized width, select s, d0/d1 inputs)
- alu (a, b, ctrl, cout, zero, result)
- flopr (parameterized width, async active-high reset to RESET_VALUE)
REQ-032 result_q and zero_q SHALL share one flopr instance of width WIDTH+1.

Verification
REQ-033 ADD: srca=5, regb=7, alusrc=0, aluctrl=010 -> result=12, zero=0, cout=0; result_q=12 after the next edge.
REQ-034 SUB equal: srca=regb=0x00001234, aluctrl=110 -> result=0, zero=1, cout=1; zero_q=1 after the edge.
REQ-035 Immediate select: srca=0x00400004, imm=0xFFFFFFFC, alusrc=1, aluctrl=010 -> result=0x00400000, cout=1.
REQ-036 Logic ops with srca=0xF0F0F0F0, regb=0xFF00FF00:
- 000 -> 0xF000F000
- 001 -> 0xFFF0FFF0
- 100 -> 0x00F000F0
- 101 -> 0xF0FFF0FF
REQ-037 SLT: (0xFFFFFFFF,1) -> 1; (1,0xFFFFFFFF) -> 0; (0x80000000,1) -> 1; (5,5) -> 0 with zero=1.
REQ-038 Reset: with result_q=12, assert reset between edges -> result_q=0 and zero_q=0 immediately; result is unchanged.
